// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner: synchronize, debounce and one-shot the vending machine buttons;
// coins are serialized (qu > di > ni) so at most one coin pulse leaves per cycle.
module vm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic ni_raw,
    input  logic di_raw,
    input  logic qu_raw,
    input  logic soda_raw,
    input  logic diet_raw,
    output logic ni,
    output logic di,
    output logic qu,
    output logic soda,
    output logic diet,
    output logic sel_conflict,
    output logic busy
);
    typedef enum logic [1:0] {IDLE_LO, ARM_HI, HIGH, ARM_LO} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0] raw, qual, qual_q;
    logic [2:0] pend, grant;
    logic [1:0] sel_q;

    assign raw = {diet_raw, soda_raw, qu_raw, di_raw, ni_raw};

    for (genvar c = 0; c < 5; c++) begin : g_ch
        logic [1:0] sync;
        logic [CNT_W-1:0] cnt, cnt_nx;
        state_t state, state_nx;
        logic q;
        assign qual[c] = q;
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                sync  <= '0;
                state <= IDLE_LO;
                cnt   <= '0;
            end else begin
                sync  <= {sync[0], raw[c]};
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            q        = 1'b0;
            case (state)
                IDLE_LO: if (sync[1]) begin
                    state_nx = ARM_HI;
                    cnt_nx   = CNT_W'(1);
                end
                ARM_HI: if (!sync[1]) begin
                    state_nx = IDLE_LO;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                    q        = 1'b1;
                end else cnt_nx = cnt + 1'b1;
                HIGH: if (!sync[1]) begin
                    state_nx = ARM_LO;
                    cnt_nx   = CNT_W'(1);
                end
                ARM_LO: if (sync[1]) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = IDLE_LO;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
                default: begin
                    state_nx = IDLE_LO;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // pend bit order: [2]=qu, [1]=di, [0]=ni
    assign grant = pend[2] ? 3'b100 : pend[1] ? 3'b010 : pend[0] ? 3'b001 : 3'b000;
    assign busy  = |pend;

    // selections take one extra register so they line up with an uncontended coin
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            qual_q       <= '0;
            pend         <= '0;
            sel_q        <= '0;
            {qu, di, ni} <= '0;
            soda         <= 1'b0;
            diet         <= 1'b0;
            sel_conflict <= 1'b0;
        end else begin
            qual_q       <= qual;
            pend         <= (pend & ~grant) | qual_q[2:0];
            {qu, di, ni} <= grant;
            sel_q        <= qual_q[4:3];
            soda         <= sel_q[0] & ~sel_q[1];
            diet         <= sel_q[1] & ~sel_q[0];
            sel_conflict <= &sel_q;
        end
    end
endmodule

// File: tb/tb_vm_input_conditioner.sv
// tb_vm_input_conditioner: directed stimulus pushes expected (output, cycle) events;
// a negedge monitor pops one event per observed high output and compares.
module tb_vm_input_conditioner;
    logic CLK = 0, rst_n = 0;
    logic ni_raw = 0, di_raw = 0, qu_raw = 0, soda_raw = 0, diet_raw = 0;
    logic ni, di, qu, soda, diet, sel_conflict, busy;
    logic [6:0] outs;
    int cyc = 0, checks = 0, passed = 0, c;

    typedef struct {int kind; int cyc;} ev_t;
    ev_t exp_q[$];
    ev_t e;
    string names[7] = '{"ni", "di", "qu", "soda", "diet", "sel_conflict", "busy"};

    vm_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .ni_raw(ni_raw), .di_raw(di_raw), .qu_raw(qu_raw),
        .soda_raw(soda_raw), .diet_raw(diet_raw),
        .ni(ni), .di(di), .qu(qu), .soda(soda), .diet(diet),
        .sel_conflict(sel_conflict), .busy(busy)
    );

    assign outs = {busy, sel_conflict, diet, soda, qu, di, ni};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        for (int k = 0; k < 7; k++) begin
            if (outs[k]) begin
                checks++;
                if (exp_q.size() == 0)
                    $display("FAIL unexpected_%s: got high at cycle %0d, required low", names[k], cyc);
                else begin
                    e = exp_q.pop_front();
                    if (e.kind == k && e.cyc == cyc) passed++;
                    else $display("FAIL event: got %s@%0d, required %s@%0d", names[k], cyc, names[e.kind], e.cyc);
                end
            end
        end
    end

    task automatic push(input int k, input int t);
        exp_q.push_back('{k, t});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_empty(input string nm);
        checks++;
        if (exp_q.size() == 0) passed++;
        else begin
            $display("FAIL %s: got %0d expected events unseen, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        idle(5);
        checks++;
        if (outs == 7'b0) passed++;
        else $display("FAIL reset_state: got %b, required 0000000", outs);
        rst_n = 1;
        idle(3);

        c = cyc; qu_raw = 1;
        push(6, c + 7); push(2, c + 8);
        idle(40); qu_raw = 0; idle(20);
        check_empty("qu_single");

        for (int i = 0; i < 10; i++) begin
            di_raw = (i % 2 == 0);
            idle(1);
        end
        c = cyc; di_raw = 1;
        push(6, c + 7); push(1, c + 8);
        idle(20); di_raw = 0; idle(20);
        check_empty("di_bounce");

        c = cyc; ni_raw = 1; di_raw = 1; qu_raw = 1;
        push(6, c + 7); push(2, c + 8); push(6, c + 8);
        push(1, c + 9); push(6, c + 9); push(0, c + 10);
        idle(20); ni_raw = 0; di_raw = 0; qu_raw = 0; idle(20);
        check_empty("coin_arbitration");

        c = cyc; soda_raw = 1; diet_raw = 1;
        push(5, c + 8);
        idle(20); soda_raw = 0; diet_raw = 0; idle(20);
        check_empty("sel_conflict");
        c = cyc; soda_raw = 1;
        push(3, c + 8);
        idle(20); soda_raw = 0; idle(20);
        check_empty("soda_single");

        c = cyc; qu_raw = 1;
        idle(6);
        @(posedge CLK); #1;
        checks++;
        if (busy === 1'b1) passed++;
        else $display("FAIL busy_before_reset: got %b, required 1", busy);
        rst_n = 0; #1;
        checks++;
        if (outs == 7'b0) passed++;
        else $display("FAIL async_reset: got %b, required 0000000", outs);
        qu_raw = 0;
        idle(5); rst_n = 1; idle(20);
        check_empty("reset_abort");

        qu_raw = 1; idle(1);
        rst_n = 0; idle(3);
        c = cyc; rst_n = 1;
        push(6, c + 7); push(2, c + 8);
        idle(20); qu_raw = 0; idle(10);
        c = cyc; qu_raw = 1;
        push(6, c + 7); push(2, c + 8);
        idle(20); qu_raw = 0; idle(10);
        check_empty("held_through_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
